// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the 4:1 round-robin mux.
// Holds the channel count and the rotating priority search.
package rr_mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // First set bit of req, searching from ptr+1 and wrapping 3->0.
  // Returns 0 when req is empty; callers gate with |req.
  function automatic sel_t rr_pick(
    input logic [NUM_CH-1:0] req,
    input sel_t              ptr
  );
    sel_t idx;
    sel_t win;
    logic hit;
    win = '0;
    hit = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = ptr + sel_t'(i);
      if (!hit && req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_mux_4x1_arb.sv
// Combinational 4-way round-robin arbiter.
// Grants the first requester after ptr when en is high.
module rr_arbiter_4
  import rr_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output sel_t              gnt_idx,
  output logic              gnt_any
);

  // Rotating priority search; one-hot grant only when enabled.
  always_comb begin
    gnt     = '0;
    gnt_idx = rr_pick(req, ptr);
    gnt_any = en && (|req);
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_mux_4x1.sv
// Four-to-one streaming mux, round-robin, registered output.
// Reports the source index of each word on out_sel.
module rr_mux_4x1
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output sel_t                    out_sel,
  input  logic                    out_ready
);

  sel_t              ptr;
  logic              load_en;
  logic [NUM_CH-1:0] gnt;
  sel_t              gnt_idx;
  logic              gnt_any;
  logic [WIDTH-1:0]  word;

  // Register is free when empty or draining this cycle.
  assign load_en = !out_valid || out_ready;

  rr_arbiter_4 u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .en      (load_en && !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign in_ready = gnt;

  // Select the granted channel's word.
  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register and last-grant pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= sel_t'(NUM_CH - 1);
    end else if (load_en) begin
      if (gnt_any) begin
        out_valid <= 1'b1;
        out_data  <= word;
        out_sel   <= gnt_idx;
        ptr       <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_4x1.sv
// Directed bench for rr_mux_4x1 with a scoreboard queue.
// A negedge monitor pops expected words on output transfers.
module tb_rr_mux_4x1;

  localparam int W = 8;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] sel;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [3:0]   in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  int vectors = 0;
  int errors  = 0;
  exp_t sb[$];

  rr_mux_4x1 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] v,
                        input logic [7:0] d0,
                        input logic [7:0] d1,
                        input logic [7:0] d2,
                        input logic [7:0] d3);
    in_valid = v;
    in_data  = {d3, d2, d1, d0};
  endtask

  task automatic push(input logic [7:0] d,
                      input logic [1:0] s);
    exp_t e;
    e.data = d;
    e.sel  = s;
    sb.push_back(e);
  endtask

  // Monitor: every output transfer must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {22'd0, out_sel, out_data}, 32'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_sel",  32'(out_sel),  32'(e.sel));
      end
    end
  end

  initial begin
    int budget;
    rst       = 1'b1;
    out_ready = 1'b1;
    set_in(4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    #1;
    chk("rst_in_ready_async", 32'(in_ready), 32'h0);
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_sel",   32'(out_sel),   32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h0);

    // 1: all valid, order 0,1,2,3,0
    rst = 1'b0;
    #0;
    push(8'hA0, 2'd0);
    push(8'hA1, 2'd1);
    push(8'hA2, 2'd2);
    push(8'hA3, 2'd3);
    push(8'hA0, 2'd0);
    chk("t1_first_gnt", 32'(in_ready), 32'h1);
    step();
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_gnt1", 32'(in_ready), 32'h2);
    repeat (4) step();

    // 6: requesters gone, output drains
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    chk("t6_no_ready", 32'(in_ready), 32'h0);
    step();
    chk("t6_valid_drop", 32'(out_valid), 32'h0);
    chk("t6_data_hold", 32'(out_data), 32'hA0);
    chk("t6_sel_hold",  32'(out_sel),  32'h0);

    // 2: lone requester on channel 2
    set_in(4'b0100, 8'h00, 8'h00, 8'h5C, 8'h00);
    for (int i = 0; i < 3; i++) begin
      push(8'h5C, 2'd2);
      #1;
      chk("t2_ready", 32'(in_ready), 32'h4);
      step();
    end
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    step();

    // 3: stall with ch1 word, then ch3 before ch0
    out_ready = 1'b0;
    set_in(4'b0010, 8'h00, 8'h11, 8'h00, 8'h00);
    push(8'h11, 2'd1);
    step();
    set_in(4'b1001, 8'h40, 8'h00, 8'h00, 8'h43);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_stall_ready", 32'(in_ready),  32'h0);
      chk("t3_stall_valid", 32'(out_valid), 32'h1);
      chk("t3_stall_data",  32'(out_data),  32'h11);
      chk("t3_stall_sel",   32'(out_sel),   32'h1);
      step();
    end
    out_ready = 1'b1;
    push(8'h43, 2'd3);
    push(8'h40, 2'd0);
    #1;
    chk("t3_gnt3", 32'(in_ready), 32'h8);
    step();
    chk("t3_gnt0", 32'(in_ready), 32'h1);
    step();
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    step();

    // 4: wrap-around after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_in(4'b1001, 8'h90, 8'h00, 8'h00, 8'h93);
    push(8'h90, 2'd0);
    push(8'h93, 2'd3);
    push(8'h90, 2'd0);
    #1;
    chk("t4_gnt0", 32'(in_ready), 32'h1);
    step();
    chk("t4_gnt3", 32'(in_ready), 32'h8);
    step();
    chk("t4_gnt0b", 32'(in_ready), 32'h1);
    step();
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    step();

    // 5: reset mid-stream drops held word
    set_in(4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    push(8'hA1, 2'd1);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("t5_rst_ready", 32'(in_ready), 32'h0);
    step();
    chk("t5_rst_valid", 32'(out_valid), 32'h0);
    chk("t5_rst_sel",   32'(out_sel),   32'h0);
    chk("t5_rst_ready2", 32'(in_ready), 32'h0);
    rst = 1'b0;
    push(8'hA0, 2'd0);
    #1;
    chk("t5_prio0", 32'(in_ready), 32'h1);
    step();
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    chk("t5_drained", 32'(out_valid), 32'h0);

    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
